// File: rtl/hamming_syndrome_stage.sv
// Purpose: syndrome stage of the pipelined (15,11) Hamming decoder; computes syndrome and one-hot error position.
// Latency: two clock edges from input handshake to out_valid; full throughput of one codeword per cycle.
// Backpressure: out_ready low freezes the output register; S1 still fills, then in_ready drops.
//
// Ports:
//   clk, reset_n           single clock, asynchronous active-low reset
//   in_valid/in_ready      input handshake; cw_in[i] is code position i+1 (parity at 1,2,4,8)
//   out_valid/out_ready    output handshake
//   cw_out                 codeword, unmodified
//   err_vec[15:1]          one-hot error position (bit p = position p), zero when clean
//   syndrome, err_flag     4-bit syndrome and its nonzero flag
//   err_count              saturating errored-transfer count, only with SYND_ERR_COUNT_EN defined
module hamming_syndrome_stage (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    input  logic [14:0]  cw_in,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [14:0]  cw_out,
    output logic [15:1]  err_vec,
    output logic [3:0]   syndrome,
    output logic         err_flag
`ifdef SYND_ERR_COUNT_EN
    ,
    output logic [15:0]  err_count
`endif
);

    // Stage 1 registers
    logic         v1_q;
    logic [14:0]  cw1_q;
    logic [3:0]   syn1_q;

    // Stage 2 registers
    logic         v2_q;
    logic [14:0]  cw2_q;
    logic [3:0]   syn2_q;
    logic [15:1]  ev2_q;

    logic         s2_take;
    logic [3:0]   syn_d;
    logic [15:1]  ev_d;

    // S2 can accept when empty or being drained; S1 can accept when empty
    // or moving into S2. Never depends on in_valid.
    assign s2_take  = !v2_q || out_ready;
    assign in_ready = !v1_q || s2_take;

    // The syndrome equals the XOR of the positions of all set bits: each
    // syndrome bit k collects the bits whose position has bit k set.
    always_comb begin
        syn_d = 4'd0;
        for (int i = 0; i < 15; i++) begin
            if (cw_in[i]) begin
                syn_d = syn_d ^ 4'(i + 1);
            end
        end
    end

    // One-hot decode of the S1 syndrome; syndrome 0 decodes to all zeros.
    always_comb begin
        ev_d = '0;
        for (int p = 1; p <= 15; p++) begin
            if (syn1_q == 4'(p)) begin
                ev_d[p] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1_q   <= 1'b0;
            cw1_q  <= '0;
            syn1_q <= '0;
            v2_q   <= 1'b0;
            cw2_q  <= '0;
            syn2_q <= '0;
            ev2_q  <= '0;
        end else begin
            if (s2_take) begin
                v2_q <= v1_q;
                if (v1_q) begin
                    cw2_q  <= cw1_q;
                    syn2_q <= syn1_q;
                    ev2_q  <= ev_d;
                end
            end
            if (in_ready) begin
                v1_q <= in_valid;
                if (in_valid) begin
                    cw1_q  <= cw_in;
                    syn1_q <= syn_d;
                end
            end
        end
    end

    assign out_valid = v2_q;
    assign cw_out    = cw2_q;
    assign err_vec   = ev2_q;
    assign syndrome  = syn2_q;
    assign err_flag  = (syn2_q != 4'd0);

`ifdef SYND_ERR_COUNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt_q <= 16'd0;
        end else if (out_valid && out_ready && err_flag && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_count = err_cnt_q;
`endif

endmodule
